// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and sizing helpers for the
// sequential radix-2 restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring step, shifting in the
// next dividend bit and producing one quotient bit.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic           borrow;

  assign shifted = {partial_rem, dividend_bit};

  // A borrow occurs when the shifted remainder is below the divisor.
  // Without a borrow the true difference is < divisor, so it fits in
  // WIDTH bits and modular subtraction of the low bits is exact.
  always_comb begin
    borrow       = (shifted < {1'b0, divisor});
    quotient_bit = ~borrow;
    new_rem      = shifted[WIDTH-1:0];
    if (!borrow)
      new_rem = shifted[WIDTH-1:0] - divisor;
  end

endmodule

// File: rtl/divider.sv
// divider: start/done sequential unsigned divider, one quotient bit
// per clock. Optional div_by_zero flag under DIVIDER_DIV0_FLAG_EN.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_DIV0_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] new_rem;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_rem (prem),
    .dividend_bit(dvd_sh[WIDTH-1]),
    .divisor     (dvs),
    .new_rem     (new_rem),
    .quotient_bit(q_bit)
  );

  // Dividend bits shift out the top while quotient bits fill the bottom.
  assign q_next = {dvd_sh[WIDTH-2:0], q_bit};

  // Control FSM and datapath registers; results load only entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_sh    <= '0;
      dvs       <= '0;
      prem      <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DIV0_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            prem   <= '0;
            cnt    <= CW'(WIDTH);
            state  <= BUSY;
          end
        end
        BUSY: begin
          dvd_sh <= q_next;
          prem   <= new_rem;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= new_rem;
`ifdef DIVIDER_DIV0_FLAG_EN
            div_by_zero <= (dvs == '0);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: vector table plus control sequences for divider,
// with a queue scoreboard popped whenever done is observed.
module tb_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIVIDER_DIV0_FLAG_EN
  logic         div_by_zero;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  exp_t sb[$];

  divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIVIDER_DIV0_FLAG_EN
    .div_by_zero(div_by_zero),
`endif
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every observed done must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL spurious_done: done seen with no pending request");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_quotient", 64'(quotient), 64'(e.q));
        check("sb_remainder", 64'(remainder), 64'(e.r));
`ifdef DIVIDER_DIV0_FLAG_EN
        check("sb_div_by_zero", 64'(div_by_zero), 64'(e.dz));
`endif
      end
    end
  end

  // Called at the negedge just after the accepting edge.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL done_timeout: no done after %0d edges", edges);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   edges;
    exp_t e;
    e.q  = v.q;
    e.r  = v.r;
    e.dz = v.dz;
    sb.push_back(e);
    launch(v.a, v.b);
    wait_done(edges);
    check("latency", 64'(edges), 64'(W + 1));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("hold_quotient", 64'(quotient), 64'(v.q));
  endtask

  vec_t vecs[$];

  initial begin
    int   edges;
    vec_t v;
    exp_t e;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    rst = 1'b0;

    vecs.push_back('{32'd10, 32'd7, 32'd1, 32'd3, 1'b0});
    vecs.push_back('{32'd100, 32'd100, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1});
    vecs.push_back('{32'd70, 32'd150, 32'd0, 32'd70, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                     32'h7FFF_FFFF, 1'b0});
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b = $urandom() >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      vecs.push_back('{a, b, a / b, a % b, 1'b0});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Restart mid-BUSY must be ignored.
    e = '{32'h5555_5555, 32'd0, 1'b0};
    sb.push_back(e);
    launch(32'hFFFF_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 12;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("busy_restart_latency", 64'(edges), 64'(W + 1));
    check("busy_restart_q", 64'(quotient), 64'h5555_5555);

    // Start held through the DONE->IDLE edge is taken one edge later.
    e = '{32'd3, 32'd2, 1'b0};
    sb.push_back(e);
    dividend = 32'd20;
    divisor  = 32'd6;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_exit_no_done", 64'(done), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check("done_exit_latency", 64'(edges), 64'(W + 1));
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts with no done.
    launch(32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    v = '{32'd9, 32'd2, 32'd4, 32'd1, 1'b0};
    run_vec(v);
    check("remainder_after", 64'(remainder), 64'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
